// File: rtl/scr_ctrl_pkg.sv
// Shared types and constants for the scrambler LFSR sequencer: state encoding,
// LFSR geometry and the register-map offsets of the four seed words.
package scr_ctrl_pkg;

    localparam int POLY_WIDTH = 127;
    localparam int WORD_W     = 32;
    localparam int NUM_WORDS  = 4;
    localparam int IDX_W      = 2;
    localparam int ADDR_W     = 12;

    localparam logic [ADDR_W-1:0] DEF_LFSR_BASE_ADDR = 12'h0CC;

    localparam logic [ADDR_W-1:0] WORD_OFF_0 = 12'd0;
    localparam logic [ADDR_W-1:0] WORD_OFF_1 = 12'd1;
    localparam logic [ADDR_W-1:0] WORD_OFF_2 = 12'd2;
    localparam logic [ADDR_W-1:0] WORD_OFF_3 = 12'd3;

    localparam logic [IDX_W-1:0] WORD_IDX_LAST = IDX_W'(NUM_WORDS - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_CHECK,
        ST_RUN,
        ST_FIN
    } state_e;

    function automatic logic [ADDR_W-1:0] word_addr(input logic [ADDR_W-1:0] base,
                                                    input logic [IDX_W-1:0]  idx);
        logic [ADDR_W-1:0] off;
        case (idx)
            2'd0:    off = WORD_OFF_0;
            2'd1:    off = WORD_OFF_1;
            2'd2:    off = WORD_OFF_2;
            default: off = WORD_OFF_3;
        endcase
        return base + off;
    endfunction

endpackage

// File: rtl/scr_seed_word_sel.sv
// Picks the 32-bit slice of the 127-bit seed for LFSR register word idx;
// word 3 carries the top 31 seed bits with bit 31 padded to zero.
module scr_seed_word_sel
    import scr_ctrl_pkg::*;
(
    input  logic [POLY_WIDTH-1:0] seed,
    input  logic [IDX_W-1:0]      idx,
    output logic [WORD_W-1:0]     word
);

    always_comb begin
        case (idx)
            2'd0:    word = seed[31:0];
            2'd1:    word = seed[63:32];
            2'd2:    word = seed[95:64];
            default: word = {1'b0, seed[126:96]};
        endcase
    end

endmodule

// File: rtl/scr_seq_ctrl.sv
// Scrambler LFSR sequencer: seeds the LFSR over its word write port, then steps it once
// per accepted keystream block. Define SCR_SEQ_CTRL_SEED_CHECK_EN for a post-load readback check.
module scr_seq_ctrl
    import scr_ctrl_pkg::*;
#(
    parameter logic [ADDR_W-1:0] LFSR_BASE_ADDR = DEF_LFSR_BASE_ADDR,
    parameter int                CNT_W          = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cfg_valid,
    output logic                  cfg_ready,
    input  logic [POLY_WIDTH-1:0] cfg_seed,
    input  logic [CNT_W-1:0]      cfg_nblk,
    input  logic                  abort,
    output logic                  lfsr_write,
    output logic [ADDR_W-1:0]     lfsr_addr,
    output logic [WORD_W-1:0]     lfsr_din,
    output logic                  lfsr_enable,
    input  logic [POLY_WIDTH-1:0] lfsr_dout,
    output logic                  key_valid,
    input  logic                  key_ready,
    output logic [POLY_WIDTH-1:0] key_data,
    output logic                  done,
    output logic                  done_err
);

    state_e                state_q, state_d;
    logic [POLY_WIDTH-1:0] seed_q, seed_d;
    logic [CNT_W-1:0]      nblk_q, nblk_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic                  err_q, err_d;
    logic [WORD_W-1:0]     seed_word;

    scr_seed_word_sel u_word_sel (
        .seed (seed_q),
        .idx  (idx_q),
        .word (seed_word)
    );

    assign key_data = lfsr_dout;

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            seed_q  <= '0;
            nblk_q  <= '0;
            idx_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            seed_q  <= seed_d;
            nblk_q  <= nblk_d;
            idx_q   <= idx_d;
            err_q   <= err_d;
        end
    end

    // NOTE: every signal driven here gets a default first, so no path can infer a latch.
    always_comb begin
        state_d     = state_q;
        seed_d      = seed_q;
        nblk_d      = nblk_q;
        idx_d       = idx_q;
        err_d       = err_q;
        cfg_ready   = 1'b0;
        lfsr_write  = 1'b0;
        lfsr_addr   = '0;
        lfsr_din    = '0;
        lfsr_enable = 1'b0;
        key_valid   = 1'b0;
        done        = 1'b0;
        done_err    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                cfg_ready = 1'b1;
                if (cfg_valid) begin
                    seed_d = cfg_seed;
                    nblk_d = cfg_nblk;
                    idx_d  = '0;
                    // An all-zero seed would lock the LFSR, so it is rejected without a load.
                    if (cfg_seed == '0) begin
                        err_d   = 1'b1;
                        state_d = ST_FIN;
                    end else begin
                        err_d   = 1'b0;
                        state_d = ST_LOAD;
                    end
                end
            end

            ST_LOAD: begin
                if (abort) begin
                    err_d   = 1'b1;
                    state_d = ST_FIN;
                end else begin
                    lfsr_write = 1'b1;
                    lfsr_addr  = word_addr(LFSR_BASE_ADDR, idx_q);
                    lfsr_din   = seed_word;
                    if (idx_q == WORD_IDX_LAST) begin
                        idx_d = '0;
`ifdef SCR_SEQ_CTRL_SEED_CHECK_EN
                        state_d = ST_CHECK;
`else
                        state_d = (nblk_q == '0) ? ST_FIN : ST_RUN;
`endif
                    end else begin
                        idx_d = idx_q + 2'd1;
                    end
                end
            end

`ifdef SCR_SEQ_CTRL_SEED_CHECK_EN
            ST_CHECK: begin
                if (abort || (lfsr_dout != seed_q)) begin
                    err_d   = 1'b1;
                    state_d = ST_FIN;
                end else begin
                    state_d = (nblk_q == '0) ? ST_FIN : ST_RUN;
                end
            end
`endif

            ST_RUN: begin
                if (abort) begin
                    err_d   = 1'b1;
                    state_d = ST_FIN;
                end else begin
                    key_valid   = (nblk_q != '0);
                    lfsr_enable = key_valid & key_ready;
                    if (lfsr_enable) begin
                        nblk_d = nblk_q - 1'b1;
                        if (nblk_q == CNT_W'(1)) begin
                            state_d = ST_FIN;
                        end
                    end
                end
            end

            ST_FIN: begin
                done     = 1'b1;
                done_err = err_q;
                state_d  = ST_IDLE;
            end

            default: state_d = ST_IDLE;
        endcase
    end

endmodule

// File: doc/scr_seq_ctrl.md
# scr_seq_ctrl

Sequencer for the 127-bit, 16-steps-per-cycle scrambler LFSR. It accepts a seed and block count over a valid/ready handshake, then writes the seed into the LFSR through the LFSR's four-word register write port. It then advances the LFSR once per accepted keystream block under downstream backpressure, and reports completion. It sits between the host/config logic and the LFSR datapath, and is the only driver of the LFSR's `write`/`addr`/`lfsrdin`/`enable` pins.

## Interface
- `POLY_WIDTH`, 127, LFSR width; fixed at 127 for this block.
- `LFSR_BASE_ADDR`, 12'h0CC, address of LFSR seed word 0; words 1..3 are at +1..+3.
- `CNT_W`, 16, width of the block count.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `cfg_valid`  in  1  seed/count request valid.
- `cfg_ready`  out  1  controller can accept a request.
- `cfg_seed`  in  127  LFSR seed.
- `cfg_nblk`  in  CNT_W  number of keystream blocks to emit.
- `abort`  in  1  synchronous cancel of the current job.
- `lfsr_write`  out  1  LFSR register write strobe.
- `lfsr_addr`  out  12  LFSR register address.
- `lfsr_din`  out  32  LFSR write data.
- `lfsr_enable`  out  1  advance the LFSR by one block (16 steps).
- `lfsr_dout`  in  127  current LFSR state.
- `key_valid`  out  1  keystream block available.
- `key_ready`  in  1  downstream accepts the block.
- `key_data`  out  127  keystream block; this is `lfsr_dout` passed through.
- `done`  out  1  one-cycle completion pulse.
- `done_err`  out  1  qualifies `done`: job rejected, aborted or failed the seed check.

## Operation
- States:
  - IDLE
  - LOAD, with an internal word index 0..3
  - CHECK, present only with the macro
  - RUN
  - FIN
- IDLE:
  - `cfg_ready`=1.
  - On `cfg_valid`&`cfg_ready`, latch the seed and count.
  - If the seed is all-zero, go to FIN with error set; the LFSR is not written.
  - Otherwise go to LOAD with index 0.
- LOAD, one word per cycle:
  - `lfsr_write`=1 and `lfsr_addr`=`LFSR_BASE_ADDR`+index.
  - `lfsr_din`=seed[32i+31:32i] for i=0..2.
  - For i=3, `lfsr_din`={1'b0, seed[126:96]}.
  - After index 3, go to CHECK when compiled in, otherwise to RUN; if the count is 0, go to FIN instead of RUN.
- RUN:
  - `key_valid`=1 while the remaining count is nonzero.
  - `lfsr_enable`=`key_valid`&`key_ready`. The LFSR advances only on a handshake, so the first block emitted is the seed itself.
  - Each handshake decrements the count. The handshake that brings the count to 0 moves the block to FIN.
- FIN:
  - `done`=1 for exactly one cycle, with `done_err` valid in that same cycle.
  - Return to IDLE.
- Abort: `abort`=1 in LOAD, CHECK or RUN goes to FIN with error set on the next edge. During the abort cycle, `lfsr_enable`, `lfsr_write` and `key_valid` are forced to 0. `abort` is ignored in IDLE and FIN.
- `lfsr_write` and `lfsr_enable` are never asserted in the same cycle.
- Outputs are 0 whenever the corresponding state is not active. `key_data` is always equal to `lfsr_dout`.

## Timing
- Reset values: state IDLE, and all outputs 0 except `cfg_ready`=1 and `key_data`=`lfsr_dout`. Latched seed, count and index reset to 0.
- Reset mid-job: the job is dropped with no `done` pulse. The LFSR keeps whatever it was last written.
- With the request handshake at cycle T:
  - Word writes occur in T+1..T+4.
  - The first `key_valid` is at T+5 (T+6 with the macro).
  - `done` occurs in the cycle after the last key handshake, or T+5/T+6 when the count is 0.
- Zero seed: `done`&`done_err` at T+1.
- `cfg_ready`=0 from T+1 until the cycle after `done`.
- `key_valid` stays high once asserted until the handshake completes or an abort occurs.

## Configuration
- `SCR_SEQ_CTRL_SEED_CHECK_EN` defined:
  - Adds one CHECK cycle after LOAD that compares `lfsr_dout` against the latched seed.
  - On mismatch, go to FIN with `done_err`=1; on match, proceed to RUN (or FIN with no error if the count is 0).
- Macro undefined: no CHECK state and no comparator. LOAD goes directly to RUN/FIN.

## Structure
- Package `scr_ctrl_pkg` holds:
  - the state enum;
  - `POLY_WIDTH` and the word count (4);
  - word-offset constants;
  - the default base address 12'h0CC.
- Sub-module `scr_seed_word_sel`: combinational selection of the 32-bit seed word by index, including zero-padding of word 3.

## Test plan
- Seed 127'h1, nblk=3, `key_ready`=1 → 4 writes at 0x0CC..0x0CF with data 1,0,0,0; then 3 blocks, the first equal to 127'h1, each later block equal to the LFSR state advanced 16 steps; then `done`=1, `done_err`=0.
- Seed all-ones, nblk=2, `key_ready` low for 5 cycles → `key_valid` is held and `lfsr_enable`=0 throughout the stall; word 3 `lfsr_din`=32'h7FFF_FFFF.
- Seed 0 → no `lfsr_write`; `done`&`done_err` at T+1.
- nblk=0, seed 5 → 4 writes, no `key_valid`, then `done` with no error.
- `abort` during the second RUN handshake cycle → no `lfsr_enable` in that cycle; `done`&`done_err` next cycle; `cfg_ready` the cycle after.
- `rst` pulsed during LOAD index 2 → all outputs at reset values immediately, no `done`; a new request then completes normally.
